// File: rtl/oled_spi_pkg.sv
// ============================================================================
// Module  : oled_spi_pkg
// Brief   : Shared widths and FSM state type for the OLED SPI receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package oled_spi_pkg;

    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = BYTE_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/oled_spi_receiver_if.sv
// ============================================================================
// Module  : oled_spi_receiver_if
// Brief   : Read-side bus of the received-byte FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface oled_spi_receiver_if;
    import oled_spi_pkg::*;

    logic              rd_en;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_dc;
    logic              rd_valid;

    modport master (output rd_en, input rd_data, input rd_dc, input rd_valid);
    modport slave  (input rd_en, output rd_data, output rd_dc, output rd_valid);
endinterface

`default_nettype wire

// File: rtl/oled_rx_fifo.sv
// ============================================================================
// Module  : oled_rx_fifo
// Brief   : Synchronous FIFO; head is presented combinationally, zero when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push, w_do_pop;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot the push needs.
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign head_o    = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + 1'b1;
            if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/oled_spi_receiver.sv
// ============================================================================
// Module  : oled_spi_receiver
// Brief   : SPI mode-0 slave for OLED byte streams with dc flag and FIFO.
//           Define OLED_SPI_RX_ERR_EN to enable overflow/frame_err/err_clr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oled_spi_receiver
    import oled_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               spi_cs,
    input  wire logic               spi_clk,
    input  wire logic               spi_mosi,
    input  wire logic               oled_dc,
    input  wire logic               err_clr,
    oled_spi_receiver_if.slave      rd,
    output logic                    overflow,
    output logic                    frame_err
);
    logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, mosi_sync_q, dc_sync_q;
    logic                   sclk_prev_q;
    logic                   w_cs, w_sclk, w_mosi, w_dc, w_rise;

    rx_state_e              state_q;
    logic [2:0]             cnt_q;
    logic [BYTE_W-1:0]      shreg_q;

    logic                   w_push, w_pop, w_full, w_empty, w_frame_evt;
    logic [ENTRY_W-1:0]     w_push_data, w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q   <= '1;
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0],  spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   oled_dc};
            sclk_prev_q <= w_sclk;
        end
    end

    assign w_cs   = cs_sync_q[SYNC_STAGES-1];
    assign w_sclk = clk_sync_q[SYNC_STAGES-1];
    assign w_mosi = mosi_sync_q[SYNC_STAGES-1];
    assign w_dc   = dc_sync_q[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~sclk_prev_q;

    // Deselect takes precedence over a coincident clock edge.
    assign w_push      = (state_q == SHIFT) & ~w_cs & w_rise & (cnt_q == 3'd7);
    assign w_push_data = {w_dc, shreg_q[BYTE_W-2:0], w_mosi};
    assign w_frame_evt = (state_q == SHIFT) & w_cs & (cnt_q != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    if (!w_cs) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (w_cs) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        shreg_q <= '0;
                    end else if (w_rise) begin
                        shreg_q <= {shreg_q[BYTE_W-2:0], w_mosi};
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                    shreg_q <= '0;
                end
            endcase
        end
    end

    assign w_pop = rd.rd_en & ~w_empty;

    oled_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (rd.rd_en),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full)
    );

    assign rd.rd_data  = w_head[BYTE_W-1:0];
    assign rd.rd_dc    = w_head[BYTE_W];
    assign rd.rd_valid = ~w_empty;

`ifdef OLED_SPI_RX_ERR_EN
    logic overflow_q, frame_err_q;

    // A setting event in the same cycle overrides err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (w_push & w_full & ~w_pop) overflow_q <= 1'b1;
            else if (err_clr)             overflow_q <= 1'b0;
            if (w_frame_evt)              frame_err_q <= 1'b1;
            else if (err_clr)             frame_err_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
`else
    logic w_unused_err;
    assign w_unused_err = err_clr ^ w_full ^ w_pop ^ w_frame_evt;
    assign overflow     = 1'b0;
    assign frame_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_receiver.sv
// ============================================================================
// Module  : tb_oled_spi_receiver
// Brief   : Directed self-checking bench for oled_spi_receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oled_spi_receiver;

`ifdef OLED_SPI_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, spi_cs, spi_clk, spi_mosi, oled_dc, err_clr;
    logic overflow, frame_err;
    int   vectors = 0;
    int   errors  = 0;

    oled_spi_receiver_if rd_if ();

    oled_spi_receiver #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .oled_dc   (oled_dc),
        .err_clr   (err_clr),
        .rd        (rd_if),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            #40 spi_clk = 1'b1;
            #40 spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        #40;
    endtask

    task automatic cs_high();
        #40 spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rd_if.rd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (rd_if.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rd_valid timeout: got %b want 1", name, rd_if.rd_valid);
        end
    endtask

    task automatic pop_check(input logic [7:0] b, input logic d, input string name);
        wait_valid(name);
        @(negedge clk);
        vectors++;
        if (rd_if.rd_data !== b) begin
            errors++;
            $display("FAIL %s rd_data: got %h want %h", name, rd_if.rd_data, b);
        end
        vectors++;
        if (rd_if.rd_dc !== d) begin
            errors++;
            $display("FAIL %s rd_dc: got %b want %b", name, rd_if.rd_dc, d);
        end
        rd_if.rd_en = 1'b1;
        @(negedge clk);
        rd_if.rd_en = 1'b0;
    endtask

    task automatic check_bit(input logic got, input logic want, input string name);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        oled_dc = 1'b0; err_clr = 1'b0; rd_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_bit(rd_if.rd_valid, 1'b0, "reset rd_valid");
        vectors++;
        if (rd_if.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset rd_data: got %h want 00", rd_if.rd_data);
        end
        check_bit(rd_if.rd_dc, 1'b0, "reset rd_dc");
        check_bit(overflow, 1'b0, "reset overflow");
        check_bit(frame_err, 1'b0, "reset frame_err");
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        oled_dc = 1'b1;
        cs_low();
        send_bits(8'h68, 7);
        repeat (4) @(negedge clk);
        check_bit(rd_if.rd_valid, 1'b0, "single before 8th edge");
        spi_mosi = 1'b0;
        #40 spi_clk = 1'b1;
        #40 spi_clk = 1'b0;
        cs_high();
        pop_check(8'h68, 1'b1, "single");
        check_bit(rd_if.rd_valid, 1'b0, "single empty after pop");
    endtask

    task automatic test_stream();
        logic [7:0] s [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        oled_dc = 1'b1;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            send_bits(s[i], 8);
            pop_check(s[i], 1'b1, "stream");
        end
        cs_high();
        check_bit(rd_if.rd_valid, 1'b0, "stream empty");
        check_bit(overflow, 1'b0, "stream overflow");
        check_bit(frame_err, 1'b0, "stream frame_err");
    endtask

    task automatic test_cmd_data();
        cs_low();
        oled_dc = 1'b0;
        send_bits(8'hAF, 8);
        #40 oled_dc = 1'b1;
        send_bits(8'h01, 8);
        cs_high();
        pop_check(8'hAF, 1'b0, "cmd");
        pop_check(8'h01, 1'b1, "data");
    endtask

    task automatic test_overflow();
        oled_dc = 1'b1;
        cs_low();
        for (int i = 1; i <= 5; i++) send_bits(8'(i * 8'h11), 8);
        cs_high();
        check_bit(overflow, ERR_EN, "overflow set");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_bit(overflow, 1'b0, "overflow cleared");
        for (int i = 1; i <= 4; i++) pop_check(8'(i * 8'h11), 1'b1, "overflow keep");
        check_bit(rd_if.rd_valid, 1'b0, "overflow 5th dropped");
    endtask

    task automatic test_frame_err();
        oled_dc = 1'b1;
        cs_low();
        send_bits(8'hFF, 5);
        cs_high();
        check_bit(rd_if.rd_valid, 1'b0, "frame no entry");
        check_bit(frame_err, ERR_EN, "frame_err set");
        cs_low();
        send_bits(8'h3C, 8);
        cs_high();
        pop_check(8'h3C, 1'b1, "frame next byte");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_bit(frame_err, 1'b0, "frame_err cleared");
    endtask

    task automatic test_reset_mid();
        oled_dc = 1'b1;
        cs_low();
        send_bits(8'hE0, 3);
        #13 reset = 1'b1;
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        check_bit(rd_if.rd_valid, 1'b0, "midreset rd_valid");
        check_bit(frame_err, 1'b0, "midreset frame_err");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_bit(frame_err, 1'b0, "after midreset frame_err");
        check_bit(rd_if.rd_valid, 1'b0, "after midreset empty");
        cs_low();
        send_bits(8'hA5, 8);
        cs_high();
        pop_check(8'hA5, 1'b1, "after midreset byte");
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_cmd_data();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
